// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - shares one memory port between instruction fetch and load/store
//
// Ports:
//   clk, rst                   clock, synchronous active-high reset
//   if_req/if_addr/if_flush    IF read request, address, response squash
//   if_ready/if_rvalid/if_rdata  IF accept, response pulse, fetched data
//   mem_req/we/addr/wdata/width  MEM load/store request fields
//   mem_ready/mem_rvalid/mem_rdata  MEM accept, response pulse, load data (0 for stores)
//   bus_req/we/addr/wdata/width  latched request to backing memory
//   bus_gnt/bus_rvalid/bus_rdata  backing memory accept, response, read data
module mem_port_arbiter #(
   parameter int ADDR_WIDTH   = 64,
   parameter int DATA_WIDTH   = 64,
   parameter int STARVE_LIMIT = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  if_req,
   input  logic [ADDR_WIDTH-1:0] if_addr,
   input  logic                  if_flush,
   output logic                  if_ready,
   output logic                  if_rvalid,
   output logic [DATA_WIDTH-1:0] if_rdata,
   input  logic                  mem_req,
   input  logic                  mem_we,
   input  logic [ADDR_WIDTH-1:0] mem_addr,
   input  logic [DATA_WIDTH-1:0] mem_wdata,
   input  logic [2:0]            mem_width,
   output logic                  mem_ready,
   output logic                  mem_rvalid,
   output logic [DATA_WIDTH-1:0] mem_rdata,
   output logic                  bus_req,
   output logic                  bus_we,
   output logic [ADDR_WIDTH-1:0] bus_addr,
   output logic [DATA_WIDTH-1:0] bus_wdata,
   output logic [2:0]            bus_width,
   input  logic                  bus_gnt,
   input  logic                  bus_rvalid,
   input  logic [DATA_WIDTH-1:0] bus_rdata
);

   typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_RESP} state_t;

   localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

   state_t                state_q;
   logic [3:0]            starve_q;
   logic                  owner_mem_q;   // 0 = IF owns the transaction, 1 = MEM
   logic                  squash_q;
   logic                  bus_req_q;
   logic                  bus_we_q;
   logic [ADDR_WIDTH-1:0] bus_addr_q;
   logic [DATA_WIDTH-1:0] bus_wdata_q;
   logic [2:0]            bus_width_q;
   logic                  if_rvalid_q;
   logic                  mem_rvalid_q;
   logic [DATA_WIDTH-1:0] if_rdata_q;
   logic [DATA_WIDTH-1:0] mem_rdata_q;

   logic                  idle;
   logic                  if_win;
   logic                  mem_win;
   logic                  done;
   logic [3:0]            starve_d;

   // Readies are suppressed while reset is asserted so nothing is accepted
   // into a transaction that reset is about to discard.
   assign idle    = (state_q == S_IDLE) && !rst;
   assign if_win  = if_req && (!mem_req || (starve_q == LIMIT));
   assign mem_win = mem_req && !if_win;
   assign done    = ((state_q == S_REQ) && bus_gnt && bus_rvalid) ||
                    ((state_q == S_WAIT) && bus_rvalid);

   // MEM grant while IF waits bumps the counter; IF can only be waiting below the
   // limit here, since at the limit IF would have won, but saturate anyway.
   assign starve_d = !if_req          ? 4'd0 :
                     (starve_q == LIMIT) ? LIMIT : starve_q + 4'd1;

   assign if_ready   = idle && if_win;
   assign mem_ready  = idle && mem_win;
   // A flush arriving in the very cycle the IF pulse is out still squashes it.
   assign if_rvalid  = if_rvalid_q && !if_flush;
   assign if_rdata   = if_rdata_q;
   assign mem_rvalid = mem_rvalid_q;
   assign mem_rdata  = mem_rdata_q;
   assign bus_req    = bus_req_q;
   assign bus_we     = bus_we_q;
   assign bus_addr   = bus_addr_q;
   assign bus_wdata  = bus_wdata_q;
   assign bus_width  = bus_width_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= S_IDLE;
         starve_q     <= 4'd0;
         owner_mem_q  <= 1'b0;
         squash_q     <= 1'b0;
         bus_req_q    <= 1'b0;
         bus_we_q     <= 1'b0;
         bus_addr_q   <= '0;
         bus_wdata_q  <= '0;
         bus_width_q  <= 3'd0;
         if_rvalid_q  <= 1'b0;
         mem_rvalid_q <= 1'b0;
         if_rdata_q   <= '0;
         mem_rdata_q  <= '0;
      end else begin
         if_rvalid_q  <= 1'b0;
         mem_rvalid_q <= 1'b0;

         case (state_q)
            S_IDLE: begin
               squash_q <= 1'b0;
               if (mem_win) begin
                  owner_mem_q <= 1'b1;
                  starve_q    <= starve_d;
                  bus_req_q   <= 1'b1;
                  bus_we_q    <= mem_we;
                  bus_addr_q  <= mem_addr;
                  bus_wdata_q <= mem_wdata;
                  bus_width_q <= mem_width;
                  state_q     <= S_REQ;
               end else if (if_win) begin
                  owner_mem_q <= 1'b0;
                  starve_q    <= 4'd0;
                  bus_req_q   <= 1'b1;
                  bus_we_q    <= 1'b0;
                  bus_addr_q  <= if_addr;
                  bus_wdata_q <= '0;
                  bus_width_q <= 3'd2;
                  state_q     <= S_REQ;
               end
            end
            S_REQ: begin
               if (if_flush && !owner_mem_q) begin
                  squash_q <= 1'b1;
               end
               if (bus_gnt) begin
                  bus_req_q <= 1'b0;
                  state_q   <= bus_rvalid ? S_RESP : S_WAIT;
               end
            end
            S_WAIT: begin
               if (if_flush && !owner_mem_q) begin
                  squash_q <= 1'b1;
               end
               if (bus_rvalid) begin
                  state_q <= S_RESP;
               end
            end
            S_RESP: begin
               squash_q <= 1'b0;
               state_q  <= S_IDLE;
            end
            default: state_q <= S_IDLE;
         endcase

         // Response is registered on entry to RESP; the flush term covers a flush
         // that coincides with the completing cycle.
         if (done) begin
            if (owner_mem_q) begin
               mem_rvalid_q <= 1'b1;
               mem_rdata_q  <= bus_we_q ? '0 : bus_rdata;
            end else if (!squash_q && !if_flush) begin
               if_rvalid_q <= 1'b1;
               if_rdata_q  <= bus_rdata;
            end
         end
      end
   end

endmodule
